// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART's single-byte holding register and the core's MMIO
// read port. It drains the UART as soon as a byte is valid and presents bytes show-ahead.
module uart_rx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned POP_EDGE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx_valid,
  input  logic [7:0]    uart_rx_data,
  output logic          uart_rx_re,
  input  logic          core_re,
  output logic [7:0]    core_rx_data,
  output logic          core_rx_valid,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_overrun
);

  typedef enum logic [1:0] {StIdle, StAck, StSettle} fill_st_e;

  localparam logic [AW:0] DepthC = DEPTH[AW:0];

  fill_st_e        st_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            re_q, overrun_q, core_re_q;
  logic [7:0]      mem_q [DEPTH];

  logic full, push, pop_req, pop;

  // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
  assign full    = (count_q == DepthC);
  assign push    = (st_q == StIdle) && uart_rx_valid && !full;
  assign pop_req = core_re & ((POP_EDGE == 0) | ~core_re_q);
  assign pop     = pop_req && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      re_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      core_re_q <= 1'b0;
    end else begin
      core_re_q <= core_re;
      // SETTLE gives the UART a cycle to drop its valid so a byte is never captured twice.
      case (st_q)
        StIdle: begin
          if (push) begin
            re_q <= 1'b1;
            st_q <= StAck;
          end
        end
        StAck: begin
          re_q <= 1'b0;
          st_q <= StSettle;
        end
        StSettle: st_q <= StIdle;
        default: begin
          re_q <= 1'b0;
          st_q <= StIdle;
        end
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
      if ((st_q == StIdle) && uart_rx_valid && full) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= uart_rx_data;
  end

  assign uart_rx_re    = re_q;
  assign count         = count_q;
  assign overrun       = overrun_q;
  assign core_rx_valid = (count_q != '0);
  assign core_rx_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: sent bytes queue up as expectations, a negedge monitor
// tracks occupancy and checks head data and every pop; a second instance covers level pops.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_re;
  logic       core_re = 1'b0;
  logic [7:0] core_rx_data;
  logic       core_rx_valid;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  logic       u2_valid = 1'b0;
  logic [7:0] u2_data = 8'h00;
  logic       u2_re;
  logic       core_re2 = 1'b0;
  logic [7:0] data2;
  logic       valid2;
  logic [4:0] count2;
  logic       ov2;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  logic       re_prev = 1'b0;
  logic       re_was = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .POP_EDGE(1)) u_dut (
    .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_re(uart_rx_re), .core_re(core_re), .core_rx_data(core_rx_data),
    .core_rx_valid(core_rx_valid), .count(count), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  uart_rx_fifo #(.DEPTH(16), .AW(4), .POP_EDGE(0)) u_dut_lvl (
    .clk(clk), .rst(rst), .uart_rx_valid(u2_valid), .uart_rx_data(u2_data),
    .uart_rx_re(u2_re), .core_re(core_re2), .core_rx_data(data2),
    .core_rx_valid(valid2), .count(count2), .overrun(ov2), .clr_overrun(1'b0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // UART model: hold the byte until the acknowledge is seen, then drop valid.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    exp_q.push_back(b);
    n = 0;
    while (uart_rx_re !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
  endtask

  task automatic pop_one();
    @(posedge clk); #1;
    core_re = 1'b1;
    @(posedge clk); #1;
    core_re = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (model_cnt > 0 && n < 100) begin
      pop_one();
      n++;
    end
    @(posedge clk); #1;
    chk("drain_count", count, 0);
  endtask

  // Monitor: occupancy model, head-of-queue check and pop scoreboard.
  initial begin
    logic pop_req;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_cnt = 0;
        re_prev   = 1'b0;
        re_was    = 1'b0;
      end else begin
        if (uart_rx_re) begin
          chk("re_single_cycle", re_was, 0);
          chk("re_while_valid", uart_rx_valid, 1);
          chk("re_not_full", model_cnt < DEPTH, 1);
          model_cnt++;
        end
        re_was = uart_rx_re;
        chk("model_sync", model_cnt <= exp_q.size(), 1);
        chk("count", count, model_cnt);
        chk("valid", core_rx_valid, model_cnt != 0);
        if (model_cnt > 0 && exp_q.size() > 0) chk("head", core_rx_data, exp_q[0]);
        else if (model_cnt == 0) chk("empty_data", core_rx_data, 0);
        pop_req = core_re && !re_prev;
        re_prev = core_re;
        if (pop_req && model_cnt > 0 && exp_q.size() > 0) begin
          chk("pop_data", core_rx_data, exp_q.pop_front());
          model_cnt--;
        end
      end
    end
  end

  initial begin
    logic [7:0] b2 [4];
    bit         a_done;
    int         k;
    b2[0] = 8'h11; b2[1] = 8'h22; b2[2] = 8'h33; b2[3] = 8'h44;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", core_rx_valid, 0);
    chk("rst_data", core_rx_data, 0);
    chk("rst_re", uart_rx_re, 0);
    chk("rst_ovr", overrun, 0);

    // Level-pop instance: preload 4 bytes, hold core_re for 6 cycles.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      u2_valid = 1'b1;
      u2_data  = b2[i];
      @(posedge clk); #1;
      @(posedge clk); #1;
      u2_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("lvl_preload_count", count2, 4);
    chk("lvl_head0", data2, b2[0]);
    core_re2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("lvl_count", count2, (i < 3) ? 3 - i : 0);
      chk("lvl_data", data2, (i < 3) ? b2[i+1] : 0);
      chk("lvl_valid", valid2, i < 3);
    end
    core_re2 = 1'b0;

    // Single byte: acknowledge timing, then a long strobe pops exactly once.
    fork
      send_byte(8'hA5);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_re_high", uart_rx_re, 1);
        chk("t1_valid", core_rx_valid, 1);
        chk("t1_data", core_rx_data, 8'hA5);
        chk("t1_count", count, 1);
        @(posedge clk); #1;
        chk("t1_re_low", uart_rx_re, 0);
      end
    join
    @(posedge clk); #1;
    core_re = 1'b1;
    repeat (50) @(posedge clk);
    #1 core_re = 1'b0;
    chk("t1_pop_count", count, 0);
    chk("t1_pop_data", core_rx_data, 0);

    // Ordered bytes across pointer wrap, interleaved with pops.
    for (int i = 1; i <= 20; i++) begin
      send_byte(8'(i));
      if (i % 2 == 0 || model_cnt >= 14) pop_one();
    end
    drain();

    // Full, overrun, capture once space frees, then clear.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
    chk("t3_full", count, 16);
    fork
      send_byte(8'hEE);
      begin
        repeat (4) begin
          @(posedge clk); #1;
          chk("t3_no_re", uart_rx_re, 0);
        end
        chk("t3_ovr", overrun, 1);
        chk("t3_count16", count, 16);
        core_re = 1'b1;
        @(posedge clk); #1;
        core_re = 1'b0;
        chk("t3_after_pop", count, 15);
        chk("t3_re_wait", uart_rx_re, 0);
        @(posedge clk); #1;
        chk("t3_capture_re", uart_rx_re, 1);
        chk("t3_refull", count, 16);
      end
    join
    @(posedge clk); #1;
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    chk("t3_ovr_clr", overrun, 0);
    drain();

    // Simultaneous push and pop at count 3, then at full.
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    fork
      send_byte(8'h34);
      begin
        @(posedge clk); #1;
        core_re = 1'b1;
        @(posedge clk); #1;
        core_re = 1'b0;
        chk("t4_count3", count, 3);
        chk("t4_head", core_rx_data, 8'h32);
      end
    join
    for (int i = 0; i < 13; i++) send_byte(8'(8'hC0 + i));
    chk("t4_full", count, 16);
    fork
      send_byte(8'h44);
      begin
        @(posedge clk); #1;
        core_re = 1'b1;
        @(posedge clk); #1;
        core_re = 1'b0;
        chk("t4_no_cap", uart_rx_re, 0);
        chk("t4_count15", count, 15);
        @(posedge clk); #1;
        chk("t4_cap_next", uart_rx_re, 1);
        chk("t4_count16", count, 16);
      end
    join
    chk("t4_ovr", overrun, 1);
    drain();

    // Reset during the acknowledge pulse.
    chk("t5_ovr_before", overrun, 1);
    fork
      send_byte(8'h77);
      begin
        k = 0;
        @(posedge clk); #1;
        while (uart_rx_re !== 1'b1 && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        chk("t5_saw_re", uart_rx_re, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_re", uart_rx_re, 0);
        chk("t5_count", count, 0);
        chk("t5_valid", core_rx_valid, 0);
        chk("t5_ovr", overrun, 0);
      end
    join
    fork
      send_byte(8'h5A);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_idle_capture", uart_rx_re, 1);
      end
    join
    drain();

    // Randomised traffic with random pop strobes.
    a_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 6)) @(posedge clk);
          send_byte(8'($urandom));
        end
        a_done = 1'b1;
      end
      begin
        while (!a_done) begin
          @(posedge clk); #1;
          core_re = ($urandom_range(0, 3) == 0);
        end
        core_re = 1'b0;
      end
    join
    drain();

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
